// File: rtl/uart_apb_master.sv
// APB requester: one command at a time becomes an APB SETUP/ACCESS transfer,
// with wait states, SLVERR passthrough and a bounded ACCESS-phase timeout.
module uart_apb_master #(
   parameter int APB_DATA_WIDTH = 32,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                        apb_clk_in,
   input  logic                        apb_rstn_in,
   input  logic                        cmd_valid_in,
   output logic                        cmd_ready_out,
   input  logic                        cmd_write_in,
   input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr_in,
   input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata_in,
   input  logic [APB_DATA_WIDTH/8-1:0] cmd_strb_in,
   output logic                        rsp_valid_out,
   input  logic                        rsp_ready_in,
   output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_out,
   output logic                        rsp_err_out,
   output logic                        rsp_timeout_out,
   output logic [APB_ADDR_WIDTH-1:0]   apb_addr_out,
   output logic                        apb_psel_out,
   output logic                        apb_penable_out,
   output logic                        apb_write_out,
   output logic [APB_DATA_WIDTH-1:0]   apb_wdata_out,
   output logic [APB_DATA_WIDTH/8-1:0] apb_strb_out,
   input  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in,
   input  logic                        apb_ready_in,
   input  logic                        apb_slverr_in
);

   localparam int STRB_W = APB_DATA_WIDTH/8;
   // Counter holds the number of low-PREADY ACCESS edges already seen.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t                    r_state, w_state_nxt;
   logic [7:0]                r_cnt, w_cnt_nxt;
   logic                      r_psel, w_psel_nxt;
   logic                      r_pen, w_pen_nxt;
   logic                      r_write, w_write_nxt;
   logic [APB_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic [APB_DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
   logic [STRB_W-1:0]         r_strb, w_strb_nxt;
   logic                      r_rsp_valid, w_rsp_valid_nxt;
   logic [APB_DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
   logic                      r_err, w_err_nxt;
   logic                      r_to, w_to_nxt;

   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_psel_nxt      = r_psel;
      w_pen_nxt       = r_pen;
      w_write_nxt     = r_write;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_strb_nxt      = r_strb;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rdata_nxt     = r_rdata;
      w_err_nxt       = r_err;
      w_to_nxt        = r_to;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid_in) begin
               w_write_nxt = cmd_write_in;
               w_addr_nxt  = cmd_addr_in;
               w_wdata_nxt = cmd_wdata_in;
               w_strb_nxt  = cmd_write_in ? cmd_strb_in : '0;
               w_psel_nxt  = 1'b1;
               w_pen_nxt   = 1'b0;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            w_pen_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            if (apb_ready_in) begin
               w_rdata_nxt     = r_write ? '0 : apb_rdata_in;
               w_err_nxt       = apb_slverr_in;
               w_to_nxt        = 1'b0;
               w_psel_nxt      = 1'b0;
               w_pen_nxt       = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = S_RESP;
            end else if (r_cnt == TO_LAST) begin
               w_rdata_nxt     = '0;
               w_err_nxt       = 1'b1;
               w_to_nxt        = 1'b1;
               w_psel_nxt      = 1'b0;
               w_pen_nxt       = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready_in) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         r_cnt       <= '0;
         r_psel      <= 1'b0;
         r_pen       <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_strb      <= '0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_to        <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_psel      <= w_psel_nxt;
         r_pen       <= w_pen_nxt;
         r_write     <= w_write_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_strb      <= w_strb_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rdata     <= w_rdata_nxt;
         r_err       <= w_err_nxt;
         r_to        <= w_to_nxt;
      end
   end

   assign cmd_ready_out   = (r_state == S_IDLE);
   assign rsp_valid_out   = r_rsp_valid;
   assign rsp_rdata_out   = r_rdata;
   assign rsp_err_out     = r_err;
   assign rsp_timeout_out = r_to;
   assign apb_addr_out    = r_addr;
   assign apb_psel_out    = r_psel;
   assign apb_penable_out = r_pen;
   assign apb_write_out   = r_write;
   assign apb_wdata_out   = r_wdata;
   assign apb_strb_out    = r_strb;

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master: inputs change and outputs are checked
// 1 time unit after each rising edge.
module tb_uart_apb_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_to;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr, pwdata, prdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [3:0]  pstrb;

   int checks = 0;
   int failures = 0;

   uart_apb_master #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .apb_clk_in(clk), .apb_rstn_in(rst_n),
      .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready), .cmd_write_in(cmd_write),
      .cmd_addr_in(cmd_addr), .cmd_wdata_in(cmd_wdata), .cmd_strb_in(cmd_strb),
      .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready), .rsp_rdata_out(rsp_rdata),
      .rsp_err_out(rsp_err), .rsp_timeout_out(rsp_to),
      .apb_addr_out(paddr), .apb_psel_out(psel), .apb_penable_out(penable),
      .apb_write_out(pwrite), .apb_wdata_out(pwdata), .apb_strb_out(pstrb),
      .apb_rdata_in(prdata), .apb_ready_in(pready), .apb_slverr_in(pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command in IDLE and hold it for the accepting edge.
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_strb = '0; rsp_ready = 1'b1; prdata = '0; pready = 1'b1; pslverr = 1'b0;
      #1;
      chk("rst_psel", psel, 0);
      chk("rst_pen", penable, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_paddr", paddr, 0);
      chk("rst_rsp_err", {rsp_err, rsp_to}, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // zero-wait write
      issue(1'b1, 32'hA030_0004, 32'h0000_000F, 4'hF);
      chk("wr_psel_T", psel, 1);
      chk("wr_pen_T", penable, 0);
      chk("wr_cmd_ready_T", cmd_ready, 0);
      tick();
      chk("wr_pen_T1", penable, 1);
      chk("wr_paddr", paddr, 32'hA030_0004);
      chk("wr_pwdata", pwdata, 32'h0000_000F);
      chk("wr_pstrb", pstrb, 4'hF);
      chk("wr_pwrite", pwrite, 1);
      chk("wr_rsp_valid_T1", rsp_valid, 0);
      tick();
      chk("wr_rsp_valid_T2", rsp_valid, 1);
      chk("wr_rsp_err", rsp_err, 0);
      chk("wr_rsp_rdata", rsp_rdata, 0);
      chk("wr_psel_drop", {psel, penable}, 0);
      tick();
      chk("wr_rsp_clear", rsp_valid, 0);
      chk("wr_idle", cmd_ready, 1);

      // read with 3 wait states
      pready = 1'b0;
      issue(1'b0, 32'hA030_0018, 32'hFFFF_FFFF, 4'hF);
      chk("rd_pstrb_setup", pstrb, 0);
      chk("rd_pwrite", pwrite, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rd_wait_psel_pen", {psel, penable}, 2'b11);
         chk("rd_wait_rsp_valid", rsp_valid, 0);
         chk("rd_wait_pstrb", pstrb, 0);
         chk("rd_wait_paddr", paddr, 32'hA030_0018);
      end
      pready = 1'b1; prdata = 32'h1234_5678;
      tick();
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
      chk("rd_rsp_err", {rsp_err, rsp_to}, 0);
      tick();

      // SLVERR with PREADY
      pslverr = 1'b1; prdata = 32'hDEAD_BEEF;
      issue(1'b0, 32'hA030_0008, 32'h0, 4'h0);
      tick(); tick();
      chk("se_rsp_valid", rsp_valid, 1);
      chk("se_err", rsp_err, 1);
      chk("se_timeout", rsp_to, 0);
      chk("se_rdata", rsp_rdata, 32'hDEAD_BEEF);
      tick();

      // SLVERR while PREADY low is ignored
      pready = 1'b0; pslverr = 1'b1;
      issue(1'b0, 32'hA030_000C, 32'h0, 4'h0);
      tick(); tick();
      chk("sei_wait", rsp_valid, 0);
      pready = 1'b1; pslverr = 1'b0; prdata = 32'h0000_00A5;
      tick();
      chk("sei_rsp_valid", rsp_valid, 1);
      chk("sei_err", rsp_err, 0);
      chk("sei_rdata", rsp_rdata, 32'h0000_00A5);
      tick();

      // timeout after 16 low-PREADY ACCESS edges
      pready = 1'b0; prdata = 32'hFFFF_FFFF;
      issue(1'b0, 32'hA030_0010, 32'h0, 4'h0);
      tick();
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk("to_still_access", {psel, penable, rsp_valid}, 3'b110);
      end
      tick();
      chk("to_psel_pen", {psel, penable}, 0);
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_err", rsp_err, 1);
      chk("to_timeout", rsp_to, 1);
      chk("to_rdata", rsp_rdata, 0);
      tick();
      pready = 1'b1;
      issue(1'b1, 32'hA030_0004, 32'h0000_0033, 4'h3);
      tick(); tick();
      chk("after_to_valid", rsp_valid, 1);
      chk("after_to_err", {rsp_err, rsp_to}, 0);
      tick();

      // response backpressure with a second command waiting
      rsp_ready = 1'b0; prdata = 32'h0000_55AA;
      issue(1'b0, 32'hA030_0014, 32'h0, 4'h0);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hA030_0020;
      cmd_wdata = 32'hCAFE_0001; cmd_strb = 4'h1;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rdata", rsp_rdata, 32'h0000_55AA);
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_psel", psel, 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_rsp_clear", rsp_valid, 0);
      chk("bp_idle_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("bp_second_psel", psel, 1);
      chk("bp_second_addr", paddr, 32'hA030_0020);
      chk("bp_second_strb", pstrb, 4'h1);
      tick(); tick();
      chk("bp_second_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0});
      tick();

      // reset during ACCESS
      pready = 1'b0;
      issue(1'b1, 32'hA030_0024, 32'h0000_0077, 4'hF);
      tick(); tick();
      chk("rs_in_access", {psel, penable}, 2'b11);
      #1 rst_n = 1'b0;
      #1;
      chk("rs_psel_pen", {psel, penable}, 0);
      chk("rs_rsp_valid", rsp_valid, 0);
      chk("rs_cmd_ready", cmd_ready, 1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rs_no_rsp", rsp_valid, 0);
      pready = 1'b1;
      issue(1'b1, 32'hA030_0028, 32'h0000_0099, 4'hF);
      chk("rs_wr_psel", psel, 1);
      tick();
      chk("rs_wr_pwdata", pwdata, 32'h0000_0099);
      tick();
      chk("rs_wr_rsp", {rsp_valid, rsp_err, rsp_to}, 3'b100);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
